// File: rtl/nibble_seq_alu_if.sv
// Request/response bundle for nibble_seq_alu: operands and controls in,
// handshake status, result and flags out.
interface nibble_seq_alu_if;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        mode;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        flag_z;
    logic        flag_n;
    logic        flag_v;

    modport master (
        output start, a, b, sub, mode,
        input  ready, busy, done, result, flag_z, flag_n, flag_v
    );

    modport slave (
        input  start, a, b, sub, mode,
        output ready, busy, done, result, flag_z, flag_n, flag_v
    );
endinterface

// File: rtl/nibble_seq_alu.sv
// 16-bit saturating add/subtract built on one 4-bit lane, one nibble per cycle
// LSB first; mode 1 turns the four nibbles into independent saturating lanes.
module nibble_seq_alu (
    input  logic              clk,
    input  logic              rst,
    nibble_seq_alu_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_reg, state_next;
    logic [15:0] a_reg, b_reg;
    logic        sub_reg, mode_reg;
    logic [1:0]  idx_reg;
    logic        carry_reg;
    logic [15:0] partial_reg;
    logic        vacc_reg;
    logic [15:0] result_reg;
    logic        flag_z_reg, flag_n_reg, flag_v_reg;

    logic        accept;
    logic [3:0]  a_nibs [4];
    logic [3:0]  b_nibs [4];
    logic [3:0]  nib_a, eff_b, lane_out;
    logic        cin, lane_ovf;
    logic [4:0]  sum5;
    logic [15:0] merged;
    logic        ovf16, v_final;
    logic [15:0] final_result;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic; start is ignored while RUN
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (idx_reg == 2'd3) state_next = DONE;
            DONE:    state_next = bus.start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs
    always_comb begin
        bus.ready = 1'b0;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state_reg)
            IDLE:    bus.ready = 1'b1;
            RUN:     bus.busy  = 1'b1;
            DONE: begin
                bus.ready = 1'b1;
                bus.done  = 1'b1;
            end
            default: bus.ready = 1'b0;
        endcase
    end

    assign accept = (state_reg != RUN) && bus.start;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_nib
            assign a_nibs[gi] = a_reg[gi*4 +: 4];
            assign b_nibs[gi] = b_reg[gi*4 +: 4];
            // Drop the freshly computed lane into its slot of the partial result
            assign merged[gi*4 +: 4] = (idx_reg == 2'(gi)) ? lane_out
                                                           : partial_reg[gi*4 +: 4];
        end
    endgenerate

    // The single 4-bit lane; carries chain only in full-width mode
    always_comb begin
        nib_a    = a_nibs[idx_reg];
        eff_b    = sub_reg ? ~b_nibs[idx_reg] : b_nibs[idx_reg];
        cin      = (mode_reg || idx_reg == 2'd0) ? sub_reg : carry_reg;
        sum5     = {1'b0, nib_a} + {1'b0, eff_b} + {4'b0000, cin};
        lane_ovf = (nib_a[3] == eff_b[3]) && (sum5[3] != nib_a[3]);
        lane_out = sum5[3:0];
        if (mode_reg && lane_ovf)
            lane_out = nib_a[3] ? 4'h8 : 4'h7;
    end

    // On the last nibble the lane sign rule is exactly the 16-bit overflow rule
    always_comb begin
        ovf16        = !mode_reg && lane_ovf;
        v_final      = ovf16 || (mode_reg && (vacc_reg || lane_ovf));
        final_result = merged;
        if (ovf16)
            final_result = a_reg[15] ? 16'h8000 : 16'h7FFF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg       <= '0;
            b_reg       <= '0;
            sub_reg     <= 1'b0;
            mode_reg    <= 1'b0;
            idx_reg     <= '0;
            carry_reg   <= 1'b0;
            partial_reg <= '0;
            vacc_reg    <= 1'b0;
            result_reg  <= '0;
            flag_z_reg  <= 1'b0;
            flag_n_reg  <= 1'b0;
            flag_v_reg  <= 1'b0;
        end else if (accept) begin
            a_reg       <= bus.a;
            b_reg       <= bus.b;
            sub_reg     <= bus.sub;
            mode_reg    <= bus.mode;
            idx_reg     <= '0;
            carry_reg   <= 1'b0;
            partial_reg <= '0;
            vacc_reg    <= 1'b0;
            result_reg  <= '0;
            flag_z_reg  <= 1'b0;
            flag_n_reg  <= 1'b0;
            flag_v_reg  <= 1'b0;
        end else if (state_reg == RUN) begin
            idx_reg     <= idx_reg + 2'd1;
            carry_reg   <= sum5[4];
            partial_reg <= merged;
            vacc_reg    <= vacc_reg || (mode_reg && lane_ovf);
            if (idx_reg == 2'd3) begin
                result_reg <= final_result;
                flag_z_reg <= (final_result == 16'h0000);
                flag_n_reg <= final_result[15];
                flag_v_reg <= v_final;
            end
        end
    end

    assign bus.result = result_reg;
    assign bus.flag_z = flag_z_reg;
    assign bus.flag_n = flag_n_reg;
    assign bus.flag_v = flag_v_reg;
endmodule

// File: tb/tb_nibble_seq_alu.sv
// Directed-vector bench for nibble_seq_alu: reset, arithmetic, saturation,
// PADDSB lanes and handshake protocol corner cases.
module tb_nibble_seq_alu;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    nibble_seq_alu_if bus();

    nibble_seq_alu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    // Issues one operation from a negedge with ready high; returns at the
    // negedge on which done was seen (lat = -1 if it never came).
    task automatic do_op(input logic [15:0] a_v, input logic [15:0] b_v,
                         input logic s_v, input logic m_v,
                         output logic [15:0] r, output logic [2:0] f,
                         output int lat, output int busy_n, output bit run_vis);
        lat = -1; busy_n = 0; run_vis = 1'b0; r = '0; f = '0;
        bus.start = 1'b1; bus.a = a_v; bus.b = b_v; bus.sub = s_v; bus.mode = m_v;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            if (bus.busy) begin
                busy_n++;
                if (bus.result !== 16'h0000 || {bus.flag_z, bus.flag_n, bus.flag_v} !== 3'b000)
                    run_vis = 1'b1;
            end
            if (bus.done) begin
                lat = i;
                r   = bus.result;
                f   = {bus.flag_z, bus.flag_n, bus.flag_v};
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.a = 16'($urandom); bus.b = 16'($urandom);
            bus.start = 1'($urandom); bus.sub = 1'($urandom); bus.mode = 1'($urandom);
        end
        @(negedge clk);
        checks++; if (bus.result !== 16'h0000) begin failures++; $display("FAIL reset_result got=%h want=0000", bus.result); end
        checks++; if ({bus.flag_z, bus.flag_n, bus.flag_v} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b want=000", {bus.flag_z, bus.flag_n, bus.flag_v}); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", bus.done); end
        checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", bus.ready); end
        rst = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        $display("reset: result=%h ready=%b", bus.result, bus.ready);
    endtask

    task automatic test_add16();
        logic [15:0] r; logic [2:0] f; int lat, bn; bit rv;
        do_op(16'h1234, 16'h0F0F, 1'b0, 1'b0, r, f, lat, bn, rv);
        $display("add16: 1234+0F0F result=%h zvn=%b lat=%0d busy=%0d", r, f, lat, bn);
        checks++; if (lat !== 5) begin failures++; $display("FAIL add16_latency got=%0d want=5", lat); end
        checks++; if (bn !== 4) begin failures++; $display("FAIL add16_busy_cycles got=%0d want=4", bn); end
        checks++; if (rv !== 1'b0) begin failures++; $display("FAIL add16_result_hidden_in_run got=%b want=0", rv); end
        checks++; if (r !== 16'h2143) begin failures++; $display("FAIL add16_result got=%h want=2143", r); end
        checks++; if (f !== 3'b000) begin failures++; $display("FAIL add16_flags got=%b want=000", f); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0 || bus.result !== 16'h2143 || bus.ready !== 1'b1) begin
            failures++; $display("FAIL add16_idle_hold got done=%b result=%h ready=%b want done=0 result=2143 ready=1", bus.done, bus.result, bus.ready);
        end
    endtask

    task automatic test_sat16();
        logic [15:0] va [3] = '{16'h7FFF, 16'h8000, 16'h0005};
        logic [15:0] vb [3] = '{16'h0001, 16'h0001, 16'h0005};
        logic        vs [3] = '{1'b0, 1'b1, 1'b1};
        logic [15:0] er [3] = '{16'h7FFF, 16'h8000, 16'h0000};
        logic [2:0]  ef [3] = '{3'b001, 3'b011, 3'b100};
        logic [15:0] r; logic [2:0] f; int lat, bn; bit rv;
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], vs[i], 1'b0, r, f, lat, bn, rv);
            $display("sat16[%0d]: a=%h b=%h sub=%b result=%h zvn=%b", i, va[i], vb[i], vs[i], r, f);
            checks++; if (r !== er[i]) begin failures++; $display("FAIL sat16_result[%0d] got=%h want=%h", i, r, er[i]); end
            checks++; if (f !== ef[i]) begin failures++; $display("FAIL sat16_flags[%0d] got=%b want=%b", i, f, ef[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_paddsb();
        logic [15:0] va [2] = '{16'h7F18, 16'h8000};
        logic [15:0] vb [2] = '{16'h1181, 16'h1000};
        logic        vs [2] = '{1'b0, 1'b1};
        logic [15:0] er [2] = '{16'h7099, 16'h8000};
        logic [2:0]  ef [2] = '{3'b001, 3'b011};
        logic [15:0] r; logic [2:0] f; int lat, bn; bit rv;
        for (int i = 0; i < 2; i++) begin
            do_op(va[i], vb[i], vs[i], 1'b1, r, f, lat, bn, rv);
            $display("paddsb[%0d]: a=%h b=%h sub=%b result=%h zvn=%b", i, va[i], vb[i], vs[i], r, f);
            checks++; if (r !== er[i]) begin failures++; $display("FAIL paddsb_result[%0d] got=%h want=%h", i, r, er[i]); end
            checks++; if (f !== ef[i]) begin failures++; $display("FAIL paddsb_flags[%0d] got=%b want=%b", i, f, ef[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_start();
        int lat = -1;
        bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h0F0F; bus.sub = 1'b0; bus.mode = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            if (i == 2) begin
                bus.start = 1'b1; bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.sub = 1'b1; bus.mode = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) begin lat = i; break; end
            @(negedge clk);
        end
        $display("ignore_start: result=%h lat=%0d", bus.result, lat);
        checks++; if (lat !== 5) begin failures++; $display("FAIL ignore_start_latency got=%0d want=5", lat); end
        checks++; if (bus.result !== 16'h2143) begin failures++; $display("FAIL ignore_start_result got=%h want=2143", bus.result); end
        checks++; if ({bus.flag_z, bus.flag_n, bus.flag_v} !== 3'b000) begin failures++; $display("FAIL ignore_start_flags got=%b want=000", {bus.flag_z, bus.flag_n, bus.flag_v}); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        bit saw_done = 1'b0;
        bus.start = 1'b1; bus.a = 16'h4321; bus.b = 16'h1111; bus.sub = 1'b0; bus.mode = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        $display("reset_mid_run: ready=%b busy=%b done=%b result=%h", bus.ready, bus.busy, bus.done, bus.result);
        checks++; if (bus.ready !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_idle got ready=%b busy=%b want ready=1 busy=0", bus.ready, bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b want=0", bus.done); end
        checks++; if (bus.result !== 16'h0000 || {bus.flag_z, bus.flag_n, bus.flag_v} !== 3'b000) begin failures++; $display("FAIL midrst_result got=%h flags=%b want=0000 000", bus.result, {bus.flag_z, bus.flag_n, bus.flag_v}); end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL midrst_no_done got=%b want=0", saw_done); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] r; logic [2:0] f; int lat, bn; bit rv;
        do_op(16'h0100, 16'h0200, 1'b0, 1'b0, r, f, lat, bn, rv);
        $display("b2b first: result=%h zvn=%b lat=%0d", r, f, lat);
        checks++; if (r !== 16'h0300 || f !== 3'b000) begin failures++; $display("FAIL b2b_first got=%h/%b want=0300/000", r, f); end
        do_op(16'h7FFF, 16'hFFFF, 1'b1, 1'b0, r, f, lat, bn, rv);
        $display("b2b second: result=%h zvn=%b lat=%0d busy=%0d", r, f, lat, bn);
        checks++; if (lat !== 5) begin failures++; $display("FAIL b2b_latency got=%0d want=5", lat); end
        checks++; if (bn !== 4) begin failures++; $display("FAIL b2b_busy_cycles got=%0d want=4", bn); end
        checks++; if (r !== 16'h7FFF) begin failures++; $display("FAIL b2b_second_result got=%h want=7FFF", r); end
        checks++; if (f !== 3'b001) begin failures++; $display("FAIL b2b_second_flags got=%b want=001", f); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL b2b_done_single got=%b want=0", bus.done); end
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.mode = 1'b0;
        test_reset();
        test_add16();
        test_sat16();
        test_paddsb();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
